// File: rtl/copy_sched_pkg.sv
// Shared types and register indices for the copy_scheduler descriptor front end.
package copy_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DST    = 3'd1,
    ST_SRC    = 3'd2,
    ST_NW     = 3'd3,
    ST_GO     = 3'd4,
    ST_DONE   = 3'd5,
    ST_RETIRE = 3'd6
  } state_t;

  localparam logic [3:0] REG_CTRL  = 4'd0;
  localparam logic [3:0] REG_DST   = 4'd1;
  localparam logic [3:0] REG_SRC   = 4'd2;
  localparam logic [3:0] REG_N     = 4'd3;
  localparam logic [3:0] REG_DONE  = 4'd4;
  localparam logic [3:0] REG_IRQEN = 4'd5;

  localparam logic [3:0] ENG_GO  = 4'd0;
  localparam logic [3:0] ENG_DST = 4'd1;
  localparam logic [3:0] ENG_SRC = 4'd2;
  localparam logic [3:0] ENG_N   = 4'd3;

  typedef struct packed {
    logic [31:0] dst;
    logic [31:0] src;
    logic [31:0] n;
  } desc_t;

endpackage

// File: rtl/copy_scheduler_desc_fifo.sv
// Synchronous descriptor FIFO; a push while full is accepted when a pop happens in the same cycle.
module desc_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [95:0]   wdata,
  output logic [95:0]   rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [95:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign empty     = (r_count == (AW+1)'(0));
  assign full      = (r_count == (AW+1)'(DEPTH));
  assign count     = r_count;
  assign rdata     = r_mem[r_rd_ptr];
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= AW'(0);
      r_rd_ptr <= AW'(0);
      r_count  <= (AW+1)'(0);
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= wdata;
  end

endmodule

// File: rtl/copy_scheduler.sv
// Descriptor-queue front end: buffers CPU copy jobs and replays each one into the
// word-copy engine's slave port (dst, src, n, start, then a stalled completion read).
module copy_scheduler
  import copy_sched_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = 8
) (
  input  logic        clk,
  input  logic        rst,
  output logic        slave_waitrequest,
  input  logic [3:0]  slave_address,
  input  logic        slave_read,
  output logic [31:0] slave_readdata,
  input  logic        slave_write,
  input  logic [31:0] slave_writedata,
  input  logic        eng_waitrequest,
  output logic [3:0]  eng_address,
  output logic        eng_read,
  input  logic [31:0] eng_readdata,
  output logic        eng_write,
  output logic [31:0] eng_writedata,
  output logic        irq
);

  localparam int AW = $clog2(DEPTH);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_dst;
  logic [31:0] r_src;
  logic [31:0] r_n;
  logic [31:0] r_job_src;
  logic [31:0] r_job_n;
  logic [31:0] r_done_cnt;
  logic        r_ovf;
  logic        r_irq_pend;
  logic        r_irq_en;
  logic        r_eng_read;
  logic        r_eng_write;
  logic [3:0]  r_eng_address;
  logic [31:0] r_eng_writedata;

  logic        w_eng_read_nxt;
  logic        w_eng_write_nxt;
  logic [3:0]  w_eng_address_nxt;
  logic [31:0] w_eng_writedata_nxt;
  logic        w_pop;
  logic        w_retire;
  logic        w_accept;
  logic        w_push_req;
  logic        w_clr;
  logic        w_full;
  logic        w_empty;
  logic [AW:0] w_count;
  desc_t       w_head;
  desc_t       w_new_desc;
  logic [95:0] w_head_bits;
  logic [31:0] w_status;
  logic [31:0] w_rdata;
  logic        w_unused;

  assign w_push_req = slave_write & (slave_address == REG_CTRL);
  assign w_clr      = slave_write & (slave_address == REG_DONE);
  assign w_accept   = ~eng_waitrequest;
  assign w_new_desc = '{dst: r_dst, src: r_src, n: r_n};
  assign w_head     = desc_t'(w_head_bits);

  desc_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push_req),
    .pop   (w_pop),
    .wdata (w_new_desc),
    .rdata (w_head_bits),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  // Job sequencer: each state holds its engine transfer until the engine accepts it.
  always_comb begin
    w_state_nxt         = r_state;
    w_pop               = 1'b0;
    w_retire            = 1'b0;
    w_eng_read_nxt      = r_eng_read;
    w_eng_write_nxt     = r_eng_write;
    w_eng_address_nxt   = r_eng_address;
    w_eng_writedata_nxt = r_eng_writedata;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          if (w_head.n != 32'd0) begin
            w_state_nxt         = ST_DST;
            w_eng_write_nxt     = 1'b1;
            w_eng_address_nxt   = ENG_DST;
            w_eng_writedata_nxt = w_head.dst;
          end else begin
            w_state_nxt = ST_RETIRE;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DST: begin
        if (w_accept) begin
          w_state_nxt         = ST_SRC;
          w_eng_address_nxt   = ENG_SRC;
          w_eng_writedata_nxt = r_job_src;
        end else begin
          w_state_nxt = ST_DST;
        end
      end
      ST_SRC: begin
        if (w_accept) begin
          w_state_nxt         = ST_NW;
          w_eng_address_nxt   = ENG_N;
          w_eng_writedata_nxt = r_job_n;
        end else begin
          w_state_nxt = ST_SRC;
        end
      end
      ST_NW: begin
        if (w_accept) begin
          w_state_nxt         = ST_GO;
          w_eng_address_nxt   = ENG_GO;
          w_eng_writedata_nxt = 32'd0;
        end else begin
          w_state_nxt = ST_NW;
        end
      end
      ST_GO: begin
        if (w_accept) begin
          w_state_nxt       = ST_DONE;
          w_eng_write_nxt   = 1'b0;
          w_eng_read_nxt    = 1'b1;
          w_eng_address_nxt = ENG_GO;
        end else begin
          w_state_nxt = ST_GO;
        end
      end
      ST_DONE: begin
        if (w_accept) begin
          w_state_nxt    = ST_RETIRE;
          w_eng_read_nxt = 1'b0;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_RETIRE: begin
        w_retire        = 1'b1;
        w_state_nxt     = ST_IDLE;
        w_eng_read_nxt  = 1'b0;
        w_eng_write_nxt = 1'b0;
      end
      default: begin
        w_state_nxt     = ST_IDLE;
        w_eng_read_nxt  = 1'b0;
        w_eng_write_nxt = 1'b0;
      end
    endcase
  end

  // State, engine strobes and popped job copy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= ST_IDLE;
      r_eng_read      <= 1'b0;
      r_eng_write     <= 1'b0;
      r_eng_address   <= 4'd0;
      r_eng_writedata <= 32'd0;
      r_job_src       <= 32'd0;
      r_job_n         <= 32'd0;
    end else begin
      r_state         <= w_state_nxt;
      r_eng_read      <= w_eng_read_nxt;
      r_eng_write     <= w_eng_write_nxt;
      r_eng_address   <= w_eng_address_nxt;
      r_eng_writedata <= w_eng_writedata_nxt;
      if (w_pop) begin
        r_job_src <= w_head.src;
        r_job_n   <= w_head.n;
      end
    end
  end

  // CPU-visible registers; a done-count clear beats a same-cycle retire.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dst      <= 32'd0;
      r_src      <= 32'd0;
      r_n        <= 32'd0;
      r_done_cnt <= 32'd0;
      r_ovf      <= 1'b0;
      r_irq_pend <= 1'b0;
      r_irq_en   <= 1'b0;
    end else begin
      if (slave_write && slave_address == REG_DST)   r_dst    <= slave_writedata;
      if (slave_write && slave_address == REG_SRC)   r_src    <= slave_writedata;
      if (slave_write && slave_address == REG_N)     r_n      <= slave_writedata;
      if (slave_write && slave_address == REG_IRQEN) r_irq_en <= slave_writedata[0];
      if (w_clr) begin
        r_done_cnt <= 32'd0;
        r_ovf      <= 1'b0;
        r_irq_pend <= 1'b0;
      end else begin
        if (w_retire) r_done_cnt <= r_done_cnt + 32'd1;
        if (w_push_req && w_full && !w_pop) r_ovf <= 1'b1;
        if (w_retire && w_empty && !w_push_req) r_irq_pend <= 1'b1;
      end
    end
  end

  // Status word assembly.
  always_comb begin
    w_status         = 32'd0;
    w_status[CW-1:0] = CW'(w_count);
    w_status[CW]     = (r_state != ST_IDLE);
    w_status[CW+1]   = r_ovf;
    w_status[CW+2]   = r_irq_pend;
  end

  // Zero-wait read mux.
  always_comb begin
    w_rdata = 32'd0;
    case (slave_address)
      REG_CTRL:  w_rdata = w_status;
      REG_DST:   w_rdata = r_dst;
      REG_SRC:   w_rdata = r_src;
      REG_N:     w_rdata = r_n;
      REG_DONE:  w_rdata = r_done_cnt;
      REG_IRQEN: w_rdata = {31'd0, r_irq_en};
      default:   w_rdata = 32'd0;
    endcase
  end

  assign slave_readdata    = w_rdata;
  assign slave_waitrequest = 1'b0;
  assign eng_read          = r_eng_read;
  assign eng_write         = r_eng_write;
  assign eng_address       = r_eng_address;
  assign eng_writedata     = r_eng_writedata;
  assign irq               = r_irq_pend & r_irq_en;
  assign w_unused          = ^{slave_read, eng_readdata};

endmodule

// File: doc/copy_scheduler.md
Name: copy_scheduler

Overview:
- Descriptor-queue front end for the word-copy DMA engine.
- The CPU queues up to DEPTH copy jobs, each given as dst, src and n_words.
- The block sequences them one at a time into the engine's CPU-facing slave port: it writes dst, src and n, writes the start register, then issues the completion read.
- It sits between the CPU's Avalon-MM master and the engine slave, and raises an interrupt when the queue drains.

Parameters:
- DEPTH, 4, descriptor FIFO entries (power of 2, 2..16).
- CW, 8, width of the occupancy field in the status register (must satisfy CW > log2(DEPTH)).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- slave_waitrequest  out  1  CPU side; tied 0.
- slave_address  in  4  CPU side.
- slave_read  in  1  CPU side.
- slave_readdata  out  32  CPU side.
- slave_write  in  1  CPU side.
- slave_writedata  in  32  CPU side.
- eng_waitrequest  in  1  engine slave waitrequest.
- eng_address  out  4  engine register index.
- eng_read  out  1  engine read request.
- eng_readdata  in  32  engine read data; ignored.
- eng_write  out  1  engine write request.
- eng_writedata  out  32  engine write data.
- irq  out  1  level interrupt.

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high. All state is registered on the posedge of clk.
- Reset values:
  - FSM in IDLE; FIFO empty.
  - Staging registers dst, src and n = 0; done_cnt = 0.
  - overflow = 0, irq_pend = 0, irq_en = 0.
  - eng_read = 0, eng_write = 0, eng_address = 0, eng_writedata = 0.
- Reset mid-job: the FSM aborts and the queue is flushed. The engine is reset by the same system reset.
- CPU register map. slave_readdata is combinational from slave_address; reads have zero wait.
  - 0, write: push {dst, src, n} into the FIFO; writedata is ignored.
  - 0, read: status. [CW-1:0] occupancy, [CW] busy (FSM not IDLE), [CW+1] overflow, [CW+2] irq_pend; remaining bits 0.
  - 1, 2, 3: dst, src and n staging registers, read/write.
  - 4, read: done_cnt. 4, write: clears done_cnt, overflow and irq_pend.
  - 5: bit0 = irq_en, read/write.
  - 6..15: read 0, writes ignored.
- Push rules:
  - A push with occupancy == DEPTH is dropped and sets overflow, unless a pop happens in the same cycle; in that case the push is accepted.
  - A push with n == 0 is accepted and queued; such an entry is retired without touching the engine.
- Engine handshake (Avalon-MM):
  - eng_write/eng_read, eng_address and eng_writedata are held stable until a clk edge where eng_waitrequest == 0; that edge completes the transfer.
  - At most one of eng_read and eng_write is high at any time.
- FSM:
  - IDLE: if the FIFO is non-empty, pop into the job registers, then go to DST if job n != 0, otherwise go to RETIRE.
  - DST: write addr 1 = job dst; on accept go to SRC.
  - SRC: write addr 2 = job src; on accept go to NW.
  - NW: write addr 3 = job n; on accept go to GO.
  - GO: write addr 0 = 0; on accept go to DONE.
  - DONE: read addr 0, held until accept, then go to RETIRE. The engine stalls this read until the copy finishes.
  - RETIRE: done_cnt += 1; drop eng_* strobes; go to IDLE.
- Throughput: minimum 7 cycles per non-zero job (IDLE through RETIRE) plus engine stalls; 2 cycles per n == 0 job.
- done_cnt wraps modulo 2^32. If a CPU clear (addr 4 write) and RETIRE occur in the same cycle, the clear wins and done_cnt = 0.
- irq_pend is set in the cycle RETIRE sees the FIFO empty with no push in the same cycle. irq = irq_pend & irq_en.
- CPU writes to staging registers while busy affect only future pushes; the in-flight job uses its popped copy.

Decomposition:
- Package copy_sched_pkg:
  - state enum.
  - Register index constants: REG_CTRL = 0, REG_DST = 1, REG_SRC = 2, REG_N = 3, REG_DONE = 4, REG_IRQEN = 5.
  - Engine register index constants: GO = 0, DST = 1, SRC = 2, N = 3.
  - descriptor struct {dst, src, n}, 96 bits.
- Sub-module desc_fifo: synchronous FIFO, DEPTH × 96.
  - Inputs: push, pop. Outputs: full, empty, count.
  - Supports simultaneous push and pop when full.

Test Plan:
- Single job: stage dst = 0x1000, src = 0x2000, n = 3; push; the engine model stalls DONE for 20 cycles → engine sees writes 1:0x1000, 2:0x2000, 3:3, 0:0 in order, then a held read of addr 0. done_cnt = 1, busy = 0 afterwards.
- Waitstates: the engine asserts waitrequest for 2 cycles on each write → address and data stay stable while stalled, with no duplicate or skipped writes. Same final register values in the engine model.
- Queue overflow: with the engine blocked in DONE, push 6 jobs at DEPTH = 4 → occupancy reaches 4 and overflow = 1. done_cnt ends at 5 (the in-flight job plus 4 queued) once unblocked.
- n = 0 job: push n = 0, then n = 2 → the engine sees no accesses for the first job. done_cnt = 2 at the end, with only one GO write observed.
- IRQ: irq_en = 1, push 2 jobs → irq rises exactly once, after the 2nd retire. Writing addr 4 drops irq and zeroes done_cnt, even in the same cycle as a retire.
- Mid-job reset: assert rst for 1 cycle while in SRC with 3 jobs queued → next cycle all eng_* strobes are 0, occupancy = 0 and status = 0.
